bram_hex_viewer: RTL
====================

// Module: bram_hex_viewer
// PURPOSE
// Downstream read-out stage for the 48-bit x 1024 dual-port BRAM. Owns port B read-only:
// steps through addresses on a push-button, waits the RAM read latency, latches the word,
// and drives four active-low 7-segment digits with a selected 16-bit slice or the address.
// Sits beside fsm_bram, which owns port A, and replaces the single-digit decoder as board output.
// PARAMETERS
// DATA_W    48    BRAM word width; must be 48, so three 16-bit slices exist
// ADDR_W    10    BRAM address width
// RD_LAT    1     BRAM read latency in clocks; legal range 1..7
// MAX_ADDR  1023  last address; stepping past it wraps to 0
// PORTS
// clk        in   1       system clock, all logic on rising edge
// reset      in   1       asynchronous, active-low reset
// step       in   1       raw push-button, asynchronous, active-high
// slice_sel  in   2       0:word[15:0] 1:word[31:16] 2:word[47:32] 3:{6'b0,addr_b}
// q_b        in   DATA_W  BRAM port B read data
// addr_b     out  ADDR_W  BRAM port B address (registered)
// we_b       out  1       BRAM port B write enable; tied 0
// busy       out  1       1 while a read is in flight
// hex0..hex3 out  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 = least significant nibble
// BEHAVIOUR
// - step passes through a 2-FF synchroniser, then a rising-edge detector -> 1-cycle step_pulse.
// - FSM states: S_IDLE, S_ADDR, S_WAIT, S_LATCH.
//   S_IDLE: busy=0; on step_pulse, addr_b <= (addr_b==MAX_ADDR) ? 0 : addr_b+1, then go to S_ADDR.
//   S_ADDR: cnt <= 0, then go to S_WAIT.
//   S_WAIT: cnt increments; when cnt==RD_LAT-1, go to S_LATCH.
//   S_LATCH: word_q <= q_b, then go to S_IDLE.
//   busy=1 in S_ADDR, S_WAIT and S_LATCH.
// - step_pulse outside S_IDLE is dropped (no queueing, no address change).
// - Timing: step_pulse in S_IDLE at cycle T -> addr_b new at T+1 -> word_q at T+3+RD_LAT
//   -> hex outputs at T+4+RD_LAT.
// - hex digits are registered: each digit = decode(selected 16-bit value nibble), 1-cycle latency.
//   A slice_sel change is therefore visible on the next clock, in any state.
// - Decode (7'b value before inversion; output is its bitwise NOT):
//   0:0111111  1:0000110  2:1011011  3:1001111  4:1100110  5:1101101  6:1111101  7:0000111
//   8:1111111  9:1100111  A:1110111  b:1111100  c:1011000  d:1011110  E:1111001  F:1110001
// - Reset (async assert, sync deassert via the same clk) sets:
//   state=S_ADDR, addr_b=0, cnt=0, word_q=0, sync FFs=0, busy=1, hex0..3=~7'b0111111 ("0").
//   After release, word 0 is fetched automatically with no step needed.
//   Reset mid-read abandons the read; no partial word_q update.
// - Holding step high yields exactly one advance; a new advance needs release then press.
// - we_b is constant 0; the block never writes the RAM.
// TESTING
// T1 reset: hold reset=0, q_b=48'h123456789ABC -> hex=~0111111, addr_b=0.
//    Release -> busy falls after RD_LAT+3 clk; slice_sel=0 shows "9ABC".
// T2 slices: word 48'h123456789ABC latched. slice_sel 1 -> "5678"; 2 -> "1234";
//    3 with addr_b=5 -> "0005". Each change visible 1 clk after slice_sel.
// T3 step: press step once (held 20 clk) with RAM model data=addr*3 -> addr_b 0->1,
//    hex "0003" at step_pulse+4+RD_LAT; exactly one increment.
// T4 wrap: addr_b=1023, press step -> addr_b=0, word 0 reloaded.
// T5 busy drop: second step edge 1 clk after the first (RD_LAT=3) -> addr_b advances by 1 only.
// T6 mid-read reset: assert reset in S_WAIT -> outputs return to reset values at once;
//    after release, addr 0 is reread.

Source files
------------

// File: rtl/bram_hex_viewer.sv
// bram_hex_viewer: read-only port-B viewer for the 48-bit BRAM.
// Steps the port-B address on a push-button, waits out the RAM read latency,
// latches the word, and shows a 16-bit slice (or the address) on four
// active-low 7-segment digits.
//
// state   | meaning
// S_IDLE  | word displayed, waiting for a button press
// S_ADDR  | new address just driven, latency counter cleared
// S_WAIT  | counting RD_LAT clocks of RAM read latency
// S_LATCH | q_b is valid, capture it into word_q
module bram_hex_viewer #(
  parameter int DATA_W   = 48,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int MAX_ADDR = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic [1:0]        slice_sel,
  input  logic [DATA_W-1:0] q_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_b,
  output logic              busy,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_LATCH} state_t;

  localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic              rst_n;
  logic [2:0]        step_sync;
  logic              step_pulse;
  logic [2:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] word_q, word_nxt;
  logic [15:0]       disp;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1100111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b1011000;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  assign we_b = 1'b0;

  // Reset asserts asynchronously but releases on a clock edge, so every flop
  // leaves reset in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_n <= 1'b0;
    else        rst_n <= 1'b1;
  end

  // Two-flop synchroniser for the button plus one history flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_sync <= '0;
    else        step_sync <= {step_sync[1:0], step};
  end

  assign step_pulse = step_sync[1] & ~step_sync[2];

  // FSM state and datapath registers; reset lands in S_ADDR so word 0 is
  // fetched without a button press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_ADDR;
      addr_b <= '0;
      cnt    <= '0;
      word_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_b <= addr_nxt;
      cnt    <= cnt_nxt;
      word_q <= word_nxt;
    end
  end

  // Next-state and busy; presses arriving outside S_IDLE are dropped.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_b;
    cnt_nxt   = cnt;
    word_nxt  = word_q;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (step_pulse) begin
          addr_nxt  = (addr_b == ADDR_W'(MAX_ADDR)) ? '0 : addr_b + 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        word_nxt  = q_b;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Display source select; slice 3 shows the zero-extended address.
  always_comb begin
    disp = word_q[15:0];
    case (slice_sel)
      2'd1:    disp = word_q[31:16];
      2'd2:    disp = word_q[47:32];
      2'd3:    disp = {{(16 - ADDR_W){1'b0}}, addr_b};
      default: disp = word_q[15:0];
    endcase
  end

  // Registered active-low digit outputs; reset shows "0000".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex0 <= ~7'b0111111;
      hex1 <= ~7'b0111111;
      hex2 <= ~7'b0111111;
      hex3 <= ~7'b0111111;
    end else begin
      hex0 <= ~seg7(disp[3:0]);
      hex1 <= ~seg7(disp[7:4]);
      hex2 <= ~seg7(disp[11:8]);
      hex3 <= ~seg7(disp[15:12]);
    end
  end

endmodule
